// File: rtl/aclk_pkg.sv
// Shared alarm-clock types and constants: BCD digit type, time-of-day limits and tick defaults.
package aclk_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MAX_LS_DIGIT    = 4'd9;
    localparam bcd_t MAX_MS_MIN      = 4'd5;
    localparam bcd_t MAX_MS_HR       = 4'd2;
    localparam bcd_t WRAP_LS_HR_AT_2 = 4'd3;

    localparam int unsigned DEF_TICKS_PER_MIN = 15360;
    localparam int unsigned DEF_TICKS_FAST    = 256;
    localparam int unsigned DEF_CNT_W         = 14;

    // True when the four digits form a legal 24-hour HH:MM value.
    function automatic logic time_valid(bcd_t ms_hr, bcd_t ls_hr, bcd_t ms_min, bcd_t ls_min);
        logic w_digits_ok;
        logic w_hours_ok;
        w_digits_ok = (ls_min <= MAX_LS_DIGIT) && (ms_min <= MAX_MS_MIN) &&
                      (ls_hr <= MAX_LS_DIGIT) && (ms_hr <= MAX_MS_HR);
        w_hours_ok  = (ms_hr < MAX_MS_HR) || (ls_hr <= WRAP_LS_HR_AT_2);
        return w_digits_ok && w_hours_ok;
    endfunction

endpackage

// File: rtl/aclk_prescaler.sv
// Minute prescaler: counts clk cycles in normal or fast period and flags the last count.
module aclk_prescaler
    import aclk_pkg::*;
#(
    parameter int unsigned TICKS_PER_MIN = DEF_TICKS_PER_MIN,
    parameter int unsigned TICKS_FAST    = DEF_TICKS_FAST,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_fast_watch,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] LAST_NORMAL = CNT_W'(TICKS_PER_MIN - 1);
    localparam logic [CNT_W-1:0] LAST_FAST   = CNT_W'(TICKS_FAST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_last;
    logic             w_tick;

    assign w_last = i_fast_watch ? LAST_FAST : LAST_NORMAL;
    // >= so a count left above the fast limit after a mode switch wraps at once.
    assign w_tick = (r_cnt >= w_last);
    assign o_tick = w_tick;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (i_clear || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/aclk_time_counter.sv
// HH:MM BCD time-of-day counter with minute prescaler and validated parallel load.
module aclk_time_counter
    import aclk_pkg::*;
#(
    parameter int unsigned TICKS_PER_MIN = DEF_TICKS_PER_MIN,
    parameter int unsigned TICKS_FAST    = DEF_TICKS_FAST,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fast_watch,
    input  logic       load_new_c,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
    output logic       one_minute,
    output logic       load_err
);

    bcd_t r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
    bcd_t w_ms_hr, w_ls_hr, w_ms_min, w_ls_min;
    logic r_one_minute;
    logic r_load_err;
    logic w_tick;
    logic w_valid;
    logic w_load_ok;

    assign w_valid   = time_valid(new_current_time_ms_hr, new_current_time_ls_hr,
                                  new_current_time_ms_min, new_current_time_ls_min);
    assign w_load_ok = load_new_c && w_valid;

    aclk_prescaler #(
        .TICKS_PER_MIN (TICKS_PER_MIN),
        .TICKS_FAST    (TICKS_FAST),
        .CNT_W         (CNT_W)
    ) u_prescaler (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_fast_watch (fast_watch),
        .i_clear      (w_load_ok),
        .o_tick       (w_tick)
    );

    // Time one minute later; the whole cascade settles in a single cycle.
    always_comb begin
        w_ms_hr  = r_ms_hr;
        w_ls_hr  = r_ls_hr;
        w_ms_min = r_ms_min;
        w_ls_min = r_ls_min;
        if (r_ls_min != MAX_LS_DIGIT) begin
            w_ls_min = r_ls_min + 4'd1;
        end else begin
            w_ls_min = 4'd0;
            if (r_ms_min != MAX_MS_MIN) begin
                w_ms_min = r_ms_min + 4'd1;
            end else begin
                w_ms_min = 4'd0;
                if ((r_ms_hr == MAX_MS_HR) && (r_ls_hr == WRAP_LS_HR_AT_2)) begin
                    w_ms_hr = 4'd0;
                    w_ls_hr = 4'd0;
                end else if (r_ls_hr == MAX_LS_DIGIT) begin
                    w_ls_hr = 4'd0;
                    w_ms_hr = r_ms_hr + 4'd1;
                end else begin
                    w_ls_hr = r_ls_hr + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ms_hr      <= 4'd0;
            r_ls_hr      <= 4'd0;
            r_ms_min     <= 4'd0;
            r_ls_min     <= 4'd0;
            r_one_minute <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_one_minute <= 1'b0;
            r_load_err   <= load_new_c && !w_valid;
            if (w_load_ok) begin
                r_ms_hr  <= new_current_time_ms_hr;
                r_ls_hr  <= new_current_time_ls_hr;
                r_ms_min <= new_current_time_ms_min;
                r_ls_min <= new_current_time_ls_min;
            end else if (w_tick) begin
                r_ms_hr      <= w_ms_hr;
                r_ls_hr      <= w_ls_hr;
                r_ms_min     <= w_ms_min;
                r_ls_min     <= w_ls_min;
                r_one_minute <= 1'b1;
            end
        end
    end

    assign current_time_ms_hr  = r_ms_hr;
    assign current_time_ls_hr  = r_ls_hr;
    assign current_time_ms_min = r_ms_min;
    assign current_time_ls_min = r_ls_min;
    assign one_minute          = r_one_minute;
    assign load_err            = r_load_err;

endmodule

// File: tb/tb_aclk_time_counter.sv
// Directed bench for aclk_time_counter with short tick periods (normal 10, fast 4).
module tb_aclk_time_counter;

    localparam int unsigned TPM   = 10;
    localparam int unsigned TFAST = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       fast_watch = 1'b1;
    logic       load_new_c = 1'b0;
    logic [3:0] nd_ms_hr = 4'd0, nd_ls_hr = 4'd0, nd_ms_min = 4'd0, nd_ls_min = 4'd0;
    logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
    logic       one_minute, load_err;
    logic [15:0] obs_time;

    int n_checks = 0;
    int n_fail   = 0;
    int model_min;

    assign obs_time = {ms_hr, ls_hr, ms_min, ls_min};

    aclk_time_counter #(
        .TICKS_PER_MIN (TPM),
        .TICKS_FAST    (TFAST),
        .CNT_W         (4)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .fast_watch              (fast_watch),
        .load_new_c              (load_new_c),
        .new_current_time_ms_hr  (nd_ms_hr),
        .new_current_time_ls_hr  (nd_ls_hr),
        .new_current_time_ms_min (nd_ms_min),
        .new_current_time_ls_min (nd_ls_min),
        .current_time_ms_hr      (ms_hr),
        .current_time_ls_hr      (ls_hr),
        .current_time_ms_min     (ms_min),
        .current_time_ls_min     (ls_min),
        .one_minute              (one_minute),
        .load_err                (load_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input logic [15:0] exp);
        n_checks++;
        assert (obs_time === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs_time, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int m);
        int h;
        int mm;
        h  = m / 60;
        mm = m % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    function automatic logic is_legal(input logic [15:0] t);
        logic [3:0] a, b, c, d;
        {a, b, c, d} = t;
        return (d <= 4'd9) && (c <= 4'd5) && (b <= 4'd9) &&
               ((a < 4'd2) || ((a == 4'd2) && (b <= 4'd3)));
    endfunction

    // Apply a load strobe for the next edge.
    task automatic do_load(input logic [15:0] t);
        {nd_ms_hr, nd_ls_hr, nd_ms_min, nd_ls_min} = t;
        load_new_c = 1'b1;
        tick();
        load_new_c = 1'b0;
    endtask

    // One fast-mode minute from prescaler count 0; time holds, then advances on the 4th edge.
    task automatic run_minute(input string tag, input logic [15:0] before_t,
                              input logic [15:0] after_t);
        for (int i = 0; i < int'(TFAST) - 1; i++) begin
            tick();
            check_bit({tag, "_nopulse"}, one_minute, 1'b0);
            check_time({tag, "_hold"}, before_t);
        end
        tick();
        check_bit({tag, "_pulse"}, one_minute, 1'b1);
        check_time({tag, "_adv"}, after_t);
    endtask

    initial begin
        // Reset mid-count.
        reset_n = 1'b0; fast_watch = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        reset_n = 1'b0;
        tick(); tick(); tick();
        check_time("rst_time", 16'h0000);
        check_bit("rst_one_minute", one_minute, 1'b0);
        check_bit("rst_load_err", load_err, 1'b0);
        reset_n = 1'b1;
        run_minute("rst_first", 16'h0000, 16'h0001);
        tick();
        check_bit("pulse_one_cycle", one_minute, 1'b0);
        tick(); tick(); tick();
        check_time("post_rst_adv", 16'h0002);

        // Carry cascades.
        do_load(16'h2359);
        check_time("load_2359", 16'h2359);
        check_bit("load_no_pulse", one_minute, 1'b0);
        run_minute("wrap_2359", 16'h2359, 16'h0000);
        do_load(16'h0959);
        run_minute("wrap_0959", 16'h0959, 16'h1000);
        do_load(16'h1959);
        run_minute("wrap_1959", 16'h1959, 16'h2000);

        // Invalid loads at counts 0,1,2; the minute still lands on the 4th edge.
        do_load(16'h2400);
        check_bit("inv_2400_err", load_err, 1'b1);
        check_time("inv_2400_time", 16'h2000);
        do_load(16'h1260);
        check_bit("inv_1260_err", load_err, 1'b1);
        check_time("inv_1260_time", 16'h2000);
        do_load(16'h1A00);
        check_bit("inv_1A00_err", load_err, 1'b1);
        check_time("inv_1A00_time", 16'h2000);
        check_bit("inv_no_pulse", one_minute, 1'b0);
        tick();
        check_bit("inv_phase_pulse", one_minute, 1'b1);
        check_time("inv_phase_time", 16'h2001);
        check_bit("inv_err_clear", load_err, 1'b0);

        // Load in the same cycle the prescaler reaches its last count.
        tick(); tick(); tick();
        check_time("coll_pre", 16'h2001);
        do_load(16'h1234);
        check_time("coll_load", 16'h1234);
        check_bit("coll_no_pulse", one_minute, 1'b0);
        check_bit("coll_no_err", load_err, 1'b0);
        run_minute("coll_next", 16'h1234, 16'h1235);

        // Normal period, then switch to fast with count above the fast limit.
        reset_n = 1'b0; fast_watch = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < int'(TPM) - 1; i++) begin
            tick();
            check_bit("norm_nopulse", one_minute, 1'b0);
        end
        tick();
        check_bit("norm_pulse", one_minute, 1'b1);
        check_time("norm_adv", 16'h0001);
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        check_bit("sw_pre", one_minute, 1'b0);
        fast_watch = 1'b1;
        tick();
        check_bit("sw_wrap_pulse", one_minute, 1'b1);
        check_time("sw_wrap_time", 16'h0002);
        run_minute("sw_fast", 16'h0002, 16'h0003);

        // Held load keeps the prescaler cleared.
        {nd_ms_hr, nd_ls_hr, nd_ms_min, nd_ls_min} = 16'h0530;
        load_new_c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_time("held_time", 16'h0530);
            check_bit("held_no_pulse", one_minute, 1'b0);
        end
        load_new_c = 1'b0;
        run_minute("held_after", 16'h0530, 16'h0531);

        // Full day in fast mode.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_min = 0;
        for (int i = 0; i < 1440 * int'(TFAST); i++) begin
            tick();
            if ((i % int'(TFAST)) == int'(TFAST) - 1) begin
                model_min = (model_min + 1) % 1440;
                check_bit("day_pulse", one_minute, 1'b1);
            end else begin
                check_bit("day_nopulse", one_minute, 1'b0);
            end
            check_time("day_time", to_bcd(model_min));
            check_bit("day_legal", is_legal(obs_time), 1'b1);
        end
        check_time("day_end", 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
